// File: rtl/ledpanel_scan_driver.sv
// ledpanel_scan_driver: HUB75-style RGB LED matrix scanner.
// Reads pixel planes from a framebuffer RAM with a 1-cycle synchronous read.
// Each plane of each row is handled in order: shift out the row data, blank, latch, then
// display. The display time doubles with each plane, which gives binary-code modulation.
// The frame_done pulse is high in the last DISPLAY cycle of a frame. Enable and the bank
// select are sampled only at frame boundaries, so a frame is never torn.
// Optional feature macro: LEDPANEL_DBLBUF_EN. When it is defined, the fb_addr MSB is the
// bank bit, taken from buf_sel at each frame start. When it is undefined, there is a single
// framebuffer, the fb_addr MSB is 0 and buf_sel is ignored.
// dbg_state exposes the FSM state for checkers.
module ledpanel_scan_driver #(
    parameter int COLS       = 32,
    parameter int ROW_ADDR_W = 4,
    parameter int PWM_BITS   = 4,
    parameter int CLK_DIV    = 4,
    parameter int BASE_ON    = 8,
    localparam int COL_W     = $clog2(COLS),
    localparam int AW        = 1 + ROW_ADDR_W + COL_W
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    enable,
    input  logic                    buf_sel,
    output logic [AW-1:0]           fb_addr,
    input  logic [6*PWM_BITS-1:0]   fb_rdata,
    output logic                    panel_r0,
    output logic                    panel_g0,
    output logic                    panel_b0,
    output logic                    panel_r1,
    output logic                    panel_g1,
    output logic                    panel_b1,
    output logic                    panel_clk,
    output logic                    panel_lat,
    output logic                    panel_oe_n,
    output logic [ROW_ADDR_W-1:0]   panel_row,
    output logic                    frame_done,
    output logic                    busy,
    output logic [2:0]              dbg_state
);

    localparam int PH_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PL_W   = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
    localparam int ON_MAX = BASE_ON << (PWM_BITS - 1);
    localparam int ON_W   = $clog2(ON_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_BLANK   = 3'd2,
        S_LATCH   = 3'd3,
        S_DISPLAY = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [PH_W-1:0]        ph_q, ph_d;
    logic [PL_W-1:0]        plane_q, plane_d;
    logic [ROW_ADDR_W-1:0]  row_q, row_d;
    logic [ON_W-1:0]        on_q, on_d;
    logic                   bank_q, bank_d;
    logic [5:0]             rgb_q, rgb_d;
    logic [ROW_ADDR_W-1:0]  panel_row_q;

    logic                   sel_in;
    logic [ON_W-1:0]        on_len;
    logic                   last_ph, last_col, last_on, last_plane, last_row;
    logic                   frame_end;

`ifdef LEDPANEL_DBLBUF_EN
    assign sel_in = buf_sel;
`else
    // Single framebuffer: the bank bit stays 0 and buf_sel has no effect.
    logic unused_buf_sel;
    assign unused_buf_sel = buf_sel;
    assign sel_in = 1'b0;
`endif

    assign on_len     = ON_W'(BASE_ON) << plane_q;
    assign last_ph    = (ph_q == PH_W'(CLK_DIV - 1));
    assign last_col   = (col_q == COL_W'(COLS - 1));
    assign last_on    = (on_q == on_len - ON_W'(1));
    assign last_plane = (plane_q == PL_W'(PWM_BITS - 1));
    assign last_row   = (row_q == {ROW_ADDR_W{1'b1}});
    assign frame_end  = (state_q == S_DISPLAY) && last_on && last_plane && last_row;

    // State and scan counters; async reset returns everything to IDLE/zero.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            ph_q    <= '0;
            plane_q <= '0;
            row_q   <= '0;
            on_q    <= '0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            ph_q    <= ph_d;
            plane_q <= plane_d;
            row_q   <= row_d;
            on_q    <= on_d;
            bank_q  <= bank_d;
        end
    end

    // Next-state and counter sequencing for shift/blank/latch/display.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        ph_d    = ph_q;
        plane_d = plane_q;
        row_d   = row_q;
        on_d    = on_q;
        bank_d  = bank_q;
        unique case (state_q)
            S_IDLE: begin
                col_d   = '0;
                ph_d    = '0;
                plane_d = '0;
                row_d   = '0;
                on_d    = '0;
                if (enable) begin
                    bank_d  = sel_in;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_ph) begin
                    ph_d = '0;
                    if (last_col) begin
                        col_d   = '0;
                        state_d = S_BLANK;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_BLANK: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                on_d    = '0;
                state_d = S_DISPLAY;
            end
            S_DISPLAY: begin
                if (last_on) begin
                    on_d = '0;
                    if (last_plane) begin
                        plane_d = '0;
                        row_d   = row_q + ROW_ADDR_W'(1);
                        if (last_row) begin
                            // Frame boundary: resample bank and enable, no gap.
                            bank_d  = sel_in;
                            state_d = enable ? S_SHIFT : S_IDLE;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end else begin
                        plane_d = plane_q + PL_W'(1);
                        state_d = S_SHIFT;
                    end
                end else begin
                    on_d = on_q + ON_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pick bit[plane] of every colour channel from the read data.
    always_comb begin
        rgb_d = '0;
        for (int i = 0; i < 6; i++) begin
            rgb_d[5-i] = fb_rdata[(5-i)*PWM_BITS + int'(plane_q)];
        end
    end

    // Colour bits are captured in phase 1 (read data valid) and held until the next column.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rgb_q <= '0;
        end else if (state_q == S_SHIFT && ph_q == PH_W'(1)) begin
            rgb_q <= rgb_d;
        end
    end

    // The row address moves to the row being latched, so it matches the displayed data.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            panel_row_q <= '0;
        end else if (state_q == S_LATCH) begin
            panel_row_q <= row_q;
        end
    end

    assign fb_addr    = {bank_q, row_q, col_q};
    assign {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} = rgb_q;
    assign panel_clk  = (state_q == S_SHIFT) && last_ph;
    assign panel_lat  = (state_q == S_LATCH);
    assign panel_oe_n = (state_q != S_DISPLAY);
    assign panel_row  = panel_row_q;
    assign frame_done = frame_end;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ledpanel_scan_driver.sv
// Testbench for ledpanel_scan_driver with default parameters.
// The framebuffer model returns a deterministic pattern for each address.
// A scoreboard queue holds the expected colour bits for every panel_clk edge of a frame.
module tb_ledpanel_scan_driver;

    localparam int COLS     = 32;
    localparam int PWM_BITS = 4;
    localparam int BASE_ON  = 8;
    localparam int ROWS     = 16;
`ifdef LEDPANEL_DBLBUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        enable = 1'b0;
    logic        buf_sel = 1'b0;
    logic [9:0]  fb_addr;
    logic [23:0] fb_rdata = '0;
    logic        panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1;
    logic        panel_clk, panel_lat, panel_oe_n;
    logic [3:0]  panel_row;
    logic        frame_done, busy;
    logic [2:0]  dbg_state;

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    ledpanel_scan_driver dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .buf_sel(buf_sel),
        .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
        .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
        .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
        .panel_row(panel_row), .frame_done(frame_done), .busy(busy),
        .dbg_state(dbg_state)
    );

    // Pixel pattern {r0,g0,b0,r1,g1,b1}; r0 plane bits all equal col[0].
    function automatic logic [23:0] pix(input logic [9:0] a);
        logic [3:0] r0, g0, b0, r1, g1, b1;
        r0 = {4{a[0]}};
        g0 = a[3:0] ^ a[8:5];
        b0 = a[8:5];
        r1 = ~a[3:0];
        g1 = {a[9], a[4], a[6], a[1]};
        b1 = a[4:1] + a[8:5];
        return {r0, g0, b0, r1, g1, b1};
    endfunction

    // Synchronous framebuffer with 1-cycle read latency.
    always @(posedge ACLK) fb_rdata <= pix(fb_addr);

    // ---------------- scoreboard ----------------
    logic [5:0] exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic fail_now(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    // Expected colour bits for a whole frame, in scan order row/plane/col.
    task automatic push_frame(input logic bank);
        logic [9:0]  a;
        logic [23:0] p;
        for (int r = 0; r < ROWS; r++) begin
            for (int pl = 0; pl < PWM_BITS; pl++) begin
                for (int c = 0; c < COLS; c++) begin
                    a = {bank, 4'(r), 5'(c)};
                    p = pix(a);
                    exp_q.push_back({p[20+pl], p[16+pl], p[12+pl], p[8+pl], p[4+pl], p[pl]});
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_clk, prev_lat, prev_oe_n, row_chk_pend;
    int   clk_cnt, oe_run, oe_plane, exp_row, exp_plane;
    logic msb_watch = 1'b0, msb_bad = 1'b0, msb_exp = 1'b0;
    logic [5:0] e;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            prev_clk = 1'b0; prev_lat = 1'b0; prev_oe_n = 1'b1; row_chk_pend = 1'b0;
            clk_cnt = 0; oe_run = 0; oe_plane = 0; exp_row = 0; exp_plane = 0;
        end else begin
            if (row_chk_pend) begin
                chk("panel_row", 32'(panel_row), 32'(exp_row));
                row_chk_pend = 1'b0;
                exp_plane = exp_plane + 1;
                if (exp_plane == PWM_BITS) begin
                    exp_plane = 0;
                    exp_row = (exp_row + 1) % ROWS;
                end
            end
            if (panel_lat || panel_clk) chk("oe_guard", 32'(panel_oe_n), 32'd1);
            if (panel_clk && !prev_clk) begin
                if (exp_q.size() == 0) begin
                    fail_now("sb_empty");
                end else begin
                    e = exp_q.pop_front();
                    chk("rgb", 32'({panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1}), 32'(e));
                end
                if (clk_cnt == 5) chk("r0_col5", 32'(panel_r0), 32'd1);
                clk_cnt++;
            end
            if (panel_lat && !prev_lat) begin
                chk("clk_per_lat", 32'(clk_cnt), 32'(COLS));
                clk_cnt = 0;
                row_chk_pend = 1'b1;
            end
            if (!panel_oe_n) begin
                oe_run++;
            end else if (!prev_oe_n) begin
                chk("oe_width", 32'(oe_run), 32'(BASE_ON << oe_plane));
                oe_plane = (oe_plane + 1) % PWM_BITS;
                oe_run = 0;
            end
            if (msb_watch && (fb_addr[9] !== msb_exp)) msb_bad = 1'b1;
            prev_clk = panel_clk;
            prev_lat = panel_lat;
            prev_oe_n = panel_oe_n;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_fd(input int n, output int t);
        bit ok;
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < n && !ok; i++) begin
            @(negedge ACLK);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                t = cyc;
            end
        end
        if (!ok) fail_now("frame_done_wait");
    endtask

    task automatic wait_lat(input int n, output int t);
        bit ok;
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < n && !ok; i++) begin
            @(negedge ACLK);
            if (panel_lat === 1'b1) begin
                ok = 1'b1;
                t = cyc;
            end
        end
        if (!ok) fail_now("lat_wait");
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_oe_n"}, 32'(panel_oe_n), 32'd1);
        chk({tag, "_lat"}, 32'(panel_lat), 32'd0);
        chk({tag, "_clk"}, 32'(panel_clk), 32'd0);
        chk({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_rgb"}, 32'({panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1}), 32'd0);
        chk({tag, "_row"}, 32'(panel_row), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t_a, t_b, t0, t1, t2;

        // Reset held with enable high.
        ARESETN = 1'b0;
        enable = 1'b1;
        buf_sel = 1'b0;
        repeat (3) @(negedge ACLK);
        check_reset_values("reset");

        // Frame 1: row length between lat pulses of the same plane.
        push_frame(1'b0);
        ARESETN = 1'b1;
        wait_lat(2000, t_a);
        for (int i = 0; i < 4; i++) wait_lat(2000, t_b);
        chk("row_len", 32'(t_b - t_a), 32'd640);
        wait_fd(20000, t0);
        push_frame(DBL ? buf_sel : 1'b0);
        @(negedge ACLK);
        chk("fd_pulse_width", 32'(frame_done), 32'd0);

        // Frame 2: toggle buf_sel mid-frame; the bank must hold until the boundary.
        repeat (4000) @(negedge ACLK);
        buf_sel = 1'b1;
        msb_exp = 1'b0;
        msb_watch = 1'b1;
        wait_fd(20000, t1);
        msb_watch = 1'b0;
        chk("frame_period_1", 32'(t1 - t0), 32'd10240);
        chk("msb_hold", 32'(msb_bad), 32'd0);
        push_frame(DBL ? buf_sel : 1'b0);
        @(negedge ACLK);
        chk("msb_after", 32'(fb_addr[9]), 32'(DBL));

        // Frame 3: drop enable mid-frame; the frame completes, then the block goes idle.
        repeat (3000) @(negedge ACLK);
        enable = 1'b0;
        wait_fd(20000, t2);
        chk("frame_period_2", 32'(t2 - t1), 32'd10240);
        @(negedge ACLK);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_oe_n", 32'(panel_oe_n), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge ACLK);
        chk("idle_hold", 32'(busy), 32'd0);

        // Restart, then apply an async reset pulse during SHIFT.
        enable = 1'b1;
        push_frame(DBL ? buf_sel : 1'b0);
        repeat (60) @(negedge ACLK);
        chk("busy_run", 32'(busy), 32'd1);
        #2 ARESETN = 1'b0;
        #1 check_reset_values("async");
        exp_q.delete();
        enable = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (5) @(negedge ACLK);
        chk("post_reset_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
